// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-port ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned DATA_WIDTH    = 32;

  // ALU operation codes, shared with the alu inside alutop
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [2:0]               ctrl;
    logic                     src;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    imm;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Requester-side request/response channels of the ALU scheduler.
interface alu_sched_if;

  logic                                     req0_valid;
  logic                                     req0_ready;
  alu_sched_pkg::alu_req_t                  req0_op;
  logic                                     req1_valid;
  logic                                     req1_ready;
  alu_sched_pkg::alu_req_t                  req1_op;
  logic                                     resp0_valid;
  logic                                     resp0_ready;
  logic                                     resp1_valid;
  logic                                     resp1_ready;
  logic [alu_sched_pkg::DATA_WIDTH-1:0]     resp_data;
  logic                                     resp_eq;

  modport master (
    output req0_valid, req0_op, req1_valid, req1_op, resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_eq
  );

  modport slave (
    input  req0_valid, req0_op, req1_valid, req1_op, resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_eq
  );

endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // Grant selection from the current valids and the previous winner
  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    case (valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU + register-file datapath between two requesters, one op in flight.
module alu_sched
  import alu_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  alu_sched_if.slave               bus,
  output logic                     busy,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [2:0]               ALUctrl,
  output logic [DATA_WIDTH-1:0]    immOp,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    ALUout,
  input  logic                     EQ
);

  sched_state_e          state;
  alu_req_t              op_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  eq_q;
  logic                  own_q;
  logic                  last_grant;

  logic gnt_valid;
  logic gnt;
  logic accept;
  logic resp_ack;

  rr_arb2 u_arb (
    .valid       ({bus.req1_valid, bus.req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant       (gnt)
  );

  // Handshake and response qualifiers decoded from the registered state
  assign accept          = rst_n && (state == IDLE) && gnt_valid;
  assign bus.req0_ready  = accept && !gnt;
  assign bus.req1_ready  = accept && gnt;
  assign bus.resp0_valid = (state == RESP) && !own_q;
  assign bus.resp1_valid = (state == RESP) && own_q;
  assign resp_ack        = own_q ? bus.resp1_ready : bus.resp0_ready;
  assign bus.resp_data   = res_q;
  assign bus.resp_eq     = eq_q;
  assign busy            = (state != IDLE);

  // Datapath controls follow the latched op; the write strobe is EXEC-only and never targets x0
  assign ALUsrc   = op_q.src;
  assign ALUctrl  = op_q.ctrl;
  assign immOp    = op_q.imm;
  assign rs1      = op_q.rs1;
  assign rs2      = op_q.rs2;
  assign rd       = op_q.rd;
  assign RegWrite = (state == EXEC) && op_q.we && (op_q.rd != '0) && rst_n;

  // Scheduler FSM: accept, execute for one cycle, then hold the result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      res_q      <= '0;
      eq_q       <= 1'b0;
      own_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= gnt ? bus.req1_op : bus.req0_op;
            own_q <= gnt;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= ALUout;
          eq_q  <= EQ;
          state <= RESP;
        end
        RESP: begin
          if (resp_ack) begin
            last_grant <= own_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched with a behavioural datapath stand-in and a scoreboard model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     busy;
  logic                     RegWrite;
  logic                     ALUsrc;
  logic [2:0]               ALUctrl;
  logic [DATA_WIDTH-1:0]    immOp;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    ALUout;
  logic                     EQ;

  always #5 clk = ~clk;

  alu_sched_if bus ();

  alu_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .ALUctrl  (ALUctrl),
    .immOp    (immOp),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .ALUout   (ALUout),
    .EQ       (EQ)
  );

  // Datapath stand-in: register file with x0 hardwired to zero, plus ALU
  logic [DATA_WIDTH-1:0] rf [32] = '{default: '0};
  logic [DATA_WIDTH-1:0] dp_a;
  logic [DATA_WIDTH-1:0] dp_b;

  always_comb begin
    dp_a = (rs1 == '0) ? '0 : rf[rs1];
    dp_b = ALUsrc ? immOp : ((rs2 == '0) ? '0 : rf[rs2]);
    case (ALUctrl)
      ALU_AND: ALUout = dp_a & dp_b;
      ALU_OR:  ALUout = dp_a | dp_b;
      ALU_ADD: ALUout = dp_a + dp_b;
      ALU_SUB: ALUout = dp_a - dp_b;
      ALU_SLT: ALUout = ($signed(dp_a) < $signed(dp_b)) ? 32'd1 : 32'd0;
      default: ALUout = '0;
    endcase
    EQ = (dp_a == dp_b);
  end

  always @(posedge clk) begin
    if (RegWrite) rf[rd] <= ALUout;
  end

  // Scoreboard model
  typedef struct {
    bit                    own;
    logic [DATA_WIDTH-1:0] res;
    bit                    eq;
    bit                    wr;
    logic [4:0]            rd;
  } exp_t;

  exp_t                  q[$];
  bit                    acc_own[$];
  logic [DATA_WIDTH-1:0] exp_rf [32] = '{default: '0};
  int                    rw_cur = 0;
  int                    passed = 0;
  int                    total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t predict(input bit own, input alu_req_t op);
    exp_t                  e;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    a = (op.rs1 == 0) ? '0 : exp_rf[op.rs1];
    b = op.src ? op.imm : ((op.rs2 == 0) ? '0 : exp_rf[op.rs2]);
    case (op.ctrl)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: e.res = a + b;
      ALU_SUB: e.res = a - b;
      ALU_SLT: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    e.own = own;
    e.eq  = (a == b);
    e.wr  = op.we && (op.rd != 0);
    e.rd  = op.rd;
    return e;
  endfunction

  function automatic alu_req_t mk(input logic [2:0] c, input logic s, input logic w,
                                  input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                  input logic [31:0] i);
    alu_req_t r;
    r.ctrl = c; r.src = s; r.we = w; r.rs1 = a; r.rs2 = b; r.rd = d; r.imm = i;
    return r;
  endfunction

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("regwrite_in_reset", 64'(RegWrite), 64'(0));
      q.delete();
      rw_cur = 0;
    end else begin
      chk("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'(0));
      if (busy) chk("ready_while_busy", 64'(bus.req0_ready | bus.req1_ready), 64'(0));
      if (RegWrite) begin
        rw_cur++;
        chk("regwrite_has_op", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          chk("regwrite_allowed", 64'(q[0].wr), 64'(1));
          chk("regwrite_rd", 64'(rd), 64'(q[0].rd));
        end
      end
      if (bus.resp0_valid || bus.resp1_valid) begin
        chk("resp_onehot", 64'(bus.resp0_valid & bus.resp1_valid), 64'(0));
        chk("resp_pending", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          chk("resp_owner", 64'(bus.resp1_valid), 64'(q[0].own));
          chk("resp_data_model", 64'(bus.resp_data), 64'(q[0].res));
          chk("resp_eq_model", 64'(bus.resp_eq), 64'(q[0].eq));
          if ((q[0].own && bus.resp1_valid && bus.resp1_ready) ||
              (!q[0].own && bus.resp0_valid && bus.resp0_ready)) begin
            chk("regwrite_per_op", 64'(rw_cur), 64'(q[0].wr));
            if (q[0].wr) exp_rf[q[0].rd] = q[0].res;
            void'(q.pop_front());
            rw_cur = 0;
          end
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        q.push_back(predict(1'b0, bus.req0_op));
        acc_own.push_back(1'b0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        q.push_back(predict(1'b1, bus.req1_op));
        acc_own.push_back(1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit port, input alu_req_t op);
    bit ok = 1'b0;
    if (port) begin bus.req1_valid = 1'b1; bus.req1_op = op; end
    else      begin bus.req0_valid = 1'b1; bus.req0_op = op; end
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      ok = port ? bus.req1_ready : bus.req0_ready;
    end
    step();
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'(1));
  endtask

  task automatic collect(input bit port, input logic [31:0] exp_data, input bit exp_eq);
    bit seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = port ? bus.resp1_valid : bus.resp0_valid;
    end
    chk("resp_seen", 64'(seen), 64'(1));
    chk("resp_data", 64'(bus.resp_data), 64'(exp_data));
    chk("resp_eq", 64'(bus.resp_eq), 64'(exp_eq));
    step();
    if (port) bus.resp1_ready = 1'b1; else bus.resp0_ready = 1'b1;
    step();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int c = 0; c < 40 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("wait_idle", 64'(idle), 64'(1));
    step();
  endtask

  alu_req_t t0 [2];
  alu_req_t t1 [2];
  bit       exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Directed scenarios
  initial begin
    int  base;
    int  n0;
    int  n1;
    bit  a0;
    bit  a1;
    bit  seen;

    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.req0_op     = '0;
    bus.req1_op     = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    rst_n           = 1'b0;
    repeat (2) step();

    chk("reset_handshake", 64'({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, busy}), 64'(0));
    chk("reset_regwrite", 64'(RegWrite), 64'(0));
    chk("reset_dp_ctrl", 64'({ALUsrc, ALUctrl, rs1, rs2, rd}), 64'(0));
    chk("reset_imm", 64'(immOp), 64'(0));
    chk("reset_resp", 64'({bus.resp_eq, bus.resp_data}), 64'(0));
    rst_n = 1'b1;

    // Single ops through requester 0
    send(1'b0, mk(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'd7));
    collect(1'b0, 32'd7, 1'b0);
    chk("rf5_written", 64'(rf[5]), 64'(7));
    send(1'b0, mk(ALU_ADD, 1'b1, 1'b1, 5'd5, 5'd0, 5'd6, 32'd3));
    collect(1'b0, 32'd10, 1'b0);
    chk("rf6_written", 64'(rf[6]), 64'(10));

    // Tie from reset: strict alternation starting with requester 0
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    t0[0] = mk(ALU_ADD, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1);
    t1[0] = mk(ALU_SUB, 1'b0, 1'b0, 5'd6, 5'd5, 5'd0, 32'd0);
    t0[1] = mk(ALU_OR,  1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd8);
    t1[1] = mk(ALU_SLT, 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd0);
    base = acc_own.size();
    n0 = 0;
    n1 = 0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    bus.req0_valid  = 1'b1; bus.req0_op = t0[0];
    bus.req1_valid  = 1'b1; bus.req1_op = t1[0];
    for (int c = 0; c < 80 && (n0 < 2 || n1 < 2); c++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      step();
      if (a0) begin n0++; if (n0 < 2) bus.req0_op = t0[n0]; else bus.req0_valid = 1'b0; end
      if (a1) begin n1++; if (n1 < 2) bus.req1_op = t1[n1]; else bus.req1_valid = 1'b0; end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    chk("tie_count", 64'(acc_own.size() - base), 64'(4));
    if (acc_own.size() - base == 4)
      for (int i = 0; i < 4; i++) chk("tie_order", 64'(acc_own[base + i]), 64'(exp_order[i]));

    // Backpressure on requester 0 with requester 1 waiting
    send(1'b0, mk(ALU_ADD, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd5));
    bus.req1_valid = 1'b1;
    bus.req1_op    = mk(ALU_ADD, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = bus.resp0_valid;
    end
    chk("bp_resp_seen", 64'(seen), 64'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.resp0_valid), 64'(1));
      chk("bp_data", 64'(bus.resp_data), 64'(15));
      chk("bp_req1_ready", 64'(bus.req1_ready), 64'(0));
    end
    step();
    bus.resp0_ready = 1'b1;
    step();
    bus.resp0_ready = 1'b0;
    send(1'b1, mk(ALU_ADD, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd0));
    collect(1'b1, 32'd10, 1'b0);

    // Write to x0 is suppressed, response still returned
    send(1'b0, mk(ALU_ADD, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 32'd7));
    collect(1'b0, 32'd14, 1'b1);
    chk("x0_unwritten", 64'(rf[0]), 64'(0));

    // Reset while the op is in EXEC
    send(1'b0, mk(ALU_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'd55));
    chk("midop_in_exec", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midop_regwrite", 64'(RegWrite), 64'(0));
    step();
    chk("midop_idle", 64'({busy, bus.resp0_valid, bus.resp1_valid}), 64'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midop_no_resp", 64'({busy, bus.resp0_valid, bus.resp1_valid}), 64'(0));
    end
    chk("midop_rf7", 64'(rf[7]), 64'(0));
    step();

    // Recovery after the aborted op
    send(1'b1, mk(ALU_SUB, 1'b0, 1'b1, 5'd6, 5'd5, 5'd7, 32'd0));
    collect(1'b1, 32'd3, 1'b0);
    chk("rf7_after", 64'(rf[7]), 64'(3));
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
